button_event: RTL and testbench

- Sits directly downstream of the button debouncer and consumes its clean `debounced` level in the same clock domain.
- Converts the level into single-cycle event pulses: press, release, short click, long press and auto-repeat.
- Also provides a held level.
- Outputs drive the multisegment display counter/mode logic; every output is registered.

---
 rtl/button_event_pkg.sv | 18 +
 rtl/button_event_tick_timer.sv | 35 +++
 rtl/button_event.sv | 209 ++++++++++++++++++++
 tb/tb_button_event.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/button_event_pkg.sv
// button_event_pkg -- shared constants for the button event decoder.
//   * 2-bit state encodings IDLE / PRESSED / LONG_HELD / WAIT2
//   * default tick counts for a 12 MHz clock
package button_event_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE      = 2'd0;
  localparam state_t PRESSED   = 2'd1;
  localparam state_t LONG_HELD = 2'd2;
  localparam state_t WAIT2     = 2'd3;

  localparam int DEF_LONG_TICKS   = 6000000;  // 0.5 s
  localparam int DEF_REPEAT_TICKS = 1200000;  // 0.1 s
  localparam int DEF_DCLICK_TICKS = 3000000;  // 0.25 s
  localparam int DEF_CNT_W        = 24;

endpackage

// File: rtl/button_event_tick_timer.sv
// tick_timer -- saturating up-counter with a terminal-hit flag.
// Ports:
//   clk_i     system clock
//   rst_n_i   synchronous active-low reset
//   clr_i     load zero (wins over en_i)
//   en_i      count up by one; holds once the terminal value is reached
//   term_i    terminal value
//   hit_o     count equals term_i (combinational)
module tick_timer #(
  parameter int CNT_W = 24
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] term_i,
  output logic             hit_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign hit_o = (cnt_q == term_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)               cnt_d = '0;
    else if (en_i && !hit_o) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/button_event.sv
// button_event -- turns a debounced button level into single-cycle event
// pulses (press, release, short click, long press, auto-repeat, optional
// double click) plus a held level. Every output is registered; a pulse
// appears the cycle after the edge that first samples the cause.
//
// Optional feature: define DOUBLE_CLICK_EN to add the WAIT2 state and the
// double_click pulse. Without it double_click_o is constant 0 and
// short_click_o fires directly on release.
//
// Ports:
//   clk_i           system clock
//   reset_n_i       synchronous active-low reset
//   btn_i           debounced button level (same clock domain)
//   press_o         pulse on accepted press
//   release_o       pulse on release of an accepted press
//   short_click_o   pulse: released before LONG_TICKS
//   long_press_o    pulse: held LONG_TICKS cycles
//   repeat_o        pulse every REPEAT_TICKS while long-held
//   double_click_o  pulse on a double click
//   held_o          level, high while PRESSED or LONG_HELD
//
// Parameter limits: LONG_TICKS >= 2, REPEAT_TICKS >= 2,
// 2**CNT_W > max(LONG_TICKS, REPEAT_TICKS, DCLICK_TICKS).
module button_event
  import button_event_pkg::*;
#(
  parameter int LONG_TICKS   = DEF_LONG_TICKS,
  parameter int REPEAT_TICKS = DEF_REPEAT_TICKS,
  parameter int DCLICK_TICKS = DEF_DCLICK_TICKS,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic btn_i,
  output logic press_o,
  output logic release_o,
  output logic short_click_o,
  output logic long_press_o,
  output logic repeat_o,
  output logic double_click_o,
  output logic held_o
);

  localparam logic [CNT_W-1:0] LONG_M1   = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] REPEAT_M1 = CNT_W'(REPEAT_TICKS - 1);
  localparam logic [CNT_W-1:0] DCLICK_M1 = CNT_W'(DCLICK_TICKS - 1);

  state_t state_q, state_d;
  logic   btn_prev_q;
  logic   press_q, release_q, short_q, long_q, repeat_q, dbl_q, held_q;
  logic   press_d, release_d, short_d, long_d, repeat_d, dbl_d, held_d;
`ifdef DOUBLE_CLICK_EN
  logic   flag_q, flag_d;  // current press is the second of a pair
`endif

  logic             rise, fall;
  logic             t_clr, t_en, t_hit;
  logic [CNT_W-1:0] t_term;

  assign rise = btn_i & ~btn_prev_q;
  assign fall = ~btn_i & btn_prev_q;

  // Only one timing interval is live per state, so one counter serves all.
  tick_timer #(.CNT_W(CNT_W)) u_timer (
    .clk_i   (clk_i),
    .rst_n_i (reset_n_i),
    .clr_i   (t_clr),
    .en_i    (t_en),
    .term_i  (t_term),
    .hit_o   (t_hit)
  );

  always_comb begin
    state_d   = state_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    short_d   = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    dbl_d     = 1'b0;
    t_clr     = 1'b0;
    t_en      = 1'b0;
    t_term    = LONG_M1;
`ifdef DOUBLE_CLICK_EN
    flag_d    = flag_q;
`endif
    case (state_q)
      IDLE: begin
        t_clr = 1'b1;
        if (rise) begin
          press_d = 1'b1;
          state_d = PRESSED;
        end
      end
      PRESSED: begin
        t_term = LONG_M1;
        // Release beats the long-press terminal on the same cycle.
        if (fall) begin
          release_d = 1'b1;
          t_clr     = 1'b1;
`ifdef DOUBLE_CLICK_EN
          if (flag_q) begin
            dbl_d   = 1'b1;
            flag_d  = 1'b0;
            state_d = IDLE;
          end else begin
            state_d = WAIT2;
          end
`else
          short_d = 1'b1;
          state_d = IDLE;
`endif
        end else if (t_hit) begin
          long_d  = 1'b1;
          t_clr   = 1'b1;
          state_d = LONG_HELD;
`ifdef DOUBLE_CLICK_EN
          // First click of the pair is still owed its short_click.
          short_d = flag_q;
          flag_d  = 1'b0;
`endif
        end else begin
          t_en = 1'b1;
        end
      end
      LONG_HELD: begin
        t_term = REPEAT_M1;
        if (fall) begin
          release_d = 1'b1;
          t_clr     = 1'b1;
          state_d   = IDLE;
        end else if (t_hit) begin
          repeat_d = 1'b1;
          t_clr    = 1'b1;
        end else begin
          t_en = 1'b1;
        end
      end
      WAIT2: begin
        t_term = DCLICK_M1;
`ifdef DOUBLE_CLICK_EN
        if (t_hit) begin
          // Window closed: deliver the delayed click. A rise landing on
          // the closing cycle starts a fresh first press, not a pair.
          short_d = 1'b1;
          t_clr   = 1'b1;
          if (rise) begin
            press_d = 1'b1;
            state_d = PRESSED;
          end else begin
            state_d = IDLE;
          end
        end else if (rise) begin
          press_d = 1'b1;
          flag_d  = 1'b1;
          t_clr   = 1'b1;
          state_d = PRESSED;
        end else begin
          t_en = 1'b1;
        end
`else
        t_clr   = 1'b1;
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
    held_d = (state_d == PRESSED) || (state_d == LONG_HELD);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      btn_prev_q <= 1'b1;  // a button held through reset is not a press
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      short_q    <= 1'b0;
      long_q     <= 1'b0;
      repeat_q   <= 1'b0;
      dbl_q      <= 1'b0;
      held_q     <= 1'b0;
`ifdef DOUBLE_CLICK_EN
      flag_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      btn_prev_q <= btn_i;
      press_q    <= press_d;
      release_q  <= release_d;
      short_q    <= short_d;
      long_q     <= long_d;
      repeat_q   <= repeat_d;
      dbl_q      <= dbl_d;
      held_q     <= held_d;
`ifdef DOUBLE_CLICK_EN
      flag_q     <= flag_d;
`endif
    end
  end

  assign press_o        = press_q;
  assign release_o      = release_q;
  assign short_click_o  = short_q;
  assign long_press_o   = long_q;
  assign repeat_o       = repeat_q;
  assign double_click_o = dbl_q;
  assign held_o         = held_q;

endmodule

// File: tb/tb_button_event.sv
// Bench for button_event with LONG_TICKS=8, REPEAT_TICKS=4, DCLICK_TICKS=6.
// Cycle k drives btn before rising edge k; outputs seen after edge k are
// "cycle k+1". Output vector order: {press, release, short, long, repeat,
// double, held}.
module tb_button_event;

`ifdef DOUBLE_CLICK_EN
  localparam bit DC = 1'b1;
`else
  localparam bit DC = 1'b0;
`endif
  localparam int NCYC = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic btn = 1'b0;
  logic press, rel, sclick, lpress, rpt, dclick, held;

  button_event #(
    .LONG_TICKS(8), .REPEAT_TICKS(4), .DCLICK_TICKS(6), .CNT_W(8)
  ) dut (
    .clk_i          (clk),
    .reset_n_i      (reset_n),
    .btn_i          (btn),
    .press_o        (press),
    .release_o      (rel),
    .short_click_o  (sclick),
    .long_press_o   (lpress),
    .repeat_o       (rpt),
    .double_click_o (dclick),
    .held_o         (held)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          r1, l1, r2, l2;
    logic [63:0] p, rl, sc, lp, rp, db, hd;
  } vec_t;

  vec_t       vecs[8];
  logic [6:0] sb[$];
  int         tests = 0;
  int         fails = 0;

  function automatic logic [63:0] m(input int a = -1, input int b = -1,
                                    input int c = -1, input int d = -1);
    logic [63:0] r;
    r = '0;
    if (a >= 0) r[a] = 1'b1;
    if (b >= 0) r[b] = 1'b1;
    if (c >= 0) r[c] = 1'b1;
    if (d >= 0) r[d] = 1'b1;
    return r;
  endfunction

  function automatic logic [63:0] rng(input int a, input int b);
    logic [63:0] r;
    r = '0;
    for (int i = a; i <= b; i++) r[i] = 1'b1;
    return r;
  endfunction

  function automatic vec_t mk(input string n, input int r1, input int l1,
                              input int r2, input int l2,
                              input logic [63:0] p, input logic [63:0] rl,
                              input logic [63:0] sc, input logic [63:0] lp,
                              input logic [63:0] rp, input logic [63:0] db,
                              input logic [63:0] hd);
    vec_t v;
    v.name = n; v.r1 = r1; v.l1 = l1; v.r2 = r2; v.l2 = l2;
    v.p = p; v.rl = rl; v.sc = sc; v.lp = lp; v.rp = rp; v.db = db; v.hd = hd;
    return v;
  endfunction

  // Drive one cycle, queue the expectation, compare after the edge.
  task automatic step(input logic b, input logic rn, input logic [6:0] exp,
                      input string tag, input int cyc);
    logic [6:0] got, e;
    btn = b;
    reset_n = rn;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    got = {press, rel, sclick, lpress, rpt, dclick, held};
    e = sb.pop_front();
    tests++;
    if (got !== e) begin
      fails++;
      $display("FAIL %s cyc %0d got=%b exp=%b", tag, cyc, got, e);
    end
  endtask

  task automatic do_reset(input string tag);
    step(1'b0, 1'b0, 7'b0, {tag, "_rst"}, 0);
    step(1'b0, 1'b0, 7'b0, {tag, "_rst"}, 0);
    step(1'b0, 1'b1, 7'b0, {tag, "_idle"}, 0);
  endtask

  task automatic run_vec(input vec_t v);
    logic       b;
    logic [6:0] e;
    do_reset(v.name);
    for (int k = 0; k < NCYC; k++) begin
      b = ((k >= v.r1) && (k < v.r1 + v.l1)) ||
          ((v.l2 > 0) && (k >= v.r2) && (k < v.r2 + v.l2));
      e = {v.p[k+1], v.rl[k+1], v.sc[k+1], v.lp[k+1], v.rp[k+1],
           v.db[k+1], v.hd[k+1]};
      step(b, 1'b1, e, v.name, k + 1);
    end
  endtask

  initial begin
    vecs[0] = mk("short3", 2, 3, 0, 0, m(3), m(6), DC ? m(12) : m(6),
                 '0, '0, '0, rng(3, 5));
    vecs[1] = mk("long20", 0, 20, 0, 0, m(1), m(21), '0,
                 m(9), m(13, 17), '0, rng(1, 20));
    vecs[2] = mk("fall_on_term", 0, 8, 0, 0, m(1), m(9), DC ? m(15) : m(9),
                 '0, '0, '0, rng(1, 8));
    vecs[3] = mk("len9", 0, 9, 0, 0, m(1), m(10), '0,
                 m(9), '0, '0, rng(1, 9));
    vecs[4] = mk("fall_on_rep_term", 0, 12, 0, 0, m(1), m(13), '0,
                 m(9), '0, '0, rng(1, 12));
    vecs[5] = mk("gap3", 0, 2, 5, 2, m(1, 6), m(3, 8),
                 DC ? '0 : m(3, 8), '0, '0, DC ? m(8) : '0,
                 rng(1, 2) | rng(6, 7));
    vecs[6] = mk("gap10", 0, 2, 12, 2, m(1, 13), m(3, 15),
                 DC ? m(9, 21) : m(3, 15), '0, '0, '0,
                 rng(1, 2) | rng(13, 14));
    vecs[7] = mk("dbl_long", 0, 2, 5, 10, m(1, 6), m(3, 16),
                 DC ? m(14) : m(3), m(14), '0, '0,
                 rng(1, 2) | rng(6, 15));

    // Button held through reset, then released: nothing at all.
    for (int k = 0; k < 20; k++) step(1'b1, 1'b0, 7'b0, "held_thru_rst", k);
    for (int k = 0; k < 6; k++)  step(1'b1, 1'b1, 7'b0, "held_thru_rst", k);
    for (int k = 0; k < 6; k++)  step(1'b0, 1'b1, 7'b0, "held_thru_rst", k);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset while LONG_HELD: silent abort, then a fresh press works.
    do_reset("midrst");
    for (int k = 0; k < 11; k++)
      step(1'b1, 1'b1, {(k == 0), 2'b00, (k == 8), 2'b00, 1'b1}, "midrst_hold", k + 1);
    step(1'b1, 1'b0, 7'b0, "midrst_abort", 12);
    step(1'b1, 1'b0, 7'b0, "midrst_abort", 13);
    step(1'b1, 1'b1, 7'b0, "midrst_after", 14);
    step(1'b1, 1'b1, 7'b0, "midrst_after", 15);
    step(1'b0, 1'b1, 7'b0, "midrst_after", 16);
    step(1'b1, 1'b1, 7'b1000001, "midrst_press", 17);
    step(1'b1, 1'b1, 7'b0000001, "midrst_press", 18);
    step(1'b0, 1'b1, DC ? 7'b0100000 : 7'b0110000, "midrst_rel", 19);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 7'b0, "midrst_tail", 20 + k);
    step(1'b0, 1'b1, DC ? 7'b0010000 : 7'b0, "midrst_tail", 25);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
